uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver, the successor to the fixed 8N1 receiver in the UART/FIFO path. It adds configurable data width, optional parity, one or two stop bits and a configurable oversampling ratio. It also adds an input synchroniser, 3-sample majority voting, false-start rejection, and parity, framing and break reporting. It sits between the pad-side `rx` line and the RX FIFO, driven by the shared baud-tick generator.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `OVERSAMPLE`, default 16: `b_tick` pulses per bit, even, legal 8..32.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data.
- `PARITY_ODD`, default 0: 1 means odd parity, 0 means even; ignored if `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`  in  1: single system clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `b_tick`  in  1: one-`clk` pulse at OVERSAMPLE × baud rate.
- `rx`  in  1: asynchronous serial input, idle high.
- `rx_data`  out  DATA_BITS: last received word, LSB-first on the line.
- `rx_busy`  out  1: frame reception in progress.
- `rx_done`  out  1: one-`clk` pulse when a frame completes.
- `parity_err`  out  1: parity mismatch in the last frame.
- `frame_err`  out  1: a stop bit sampled low in the last frame.
- `break_det`  out  1: last frame was all-zero data with `frame_err`.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised value `rxs`.
- The tick counter `tcnt` is `$clog2(OVERSAMPLE)` bits and advances only on `b_tick`. It wraps to 0 at OVERSAMPLE-1, which marks a bit boundary.
- **Vote:** on the ticks where `tcnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, `rxs` is captured into a 3-bit register. The bit value is the majority of the three, evaluated on the OVERSAMPLE/2+1 tick.
- **IDLE:** `armed` sets when `rxs`=1. If `armed` and `rxs`=0:
  - `tcnt`, the bit counter and the shift register clear;
  - `rx_busy` goes to 1;
  - the block moves to START and clears `armed`.
- **START:**
  - If the vote is 1, the start is false: go to IDLE, `rx_busy` goes to 0, no `rx_done`.
  - Otherwise, at the wrap go to DATA.
- **DATA:**
  - Each vote shifts in at the MSB of a DATA_BITS shift register (right shift), so the first bit lands at bit 0.
  - At the wrap after bit DATA_BITS-1, go to PARITY if `PARITY_EN`, else to STOP.
- **PARITY:** the vote is stored. At the wrap, go to STOP.
- **STOP:**
  - Each stop-bit vote ORs `!vote` into a frame-error accumulator.
  - On the vote of the final stop bit, at mid-bit rather than the wrap, the block:
    - loads `rx_data` from the shift register;
    - updates `parity_err`, `frame_err` and `break_det`;
    - pulses `rx_done`;
    - drops `rx_busy`;
    - returns to IDLE.
  - With `STOP_BITS`=2 the first stop bit ends at its wrap.
- **Parity rule:** expected parity = (XOR of the data bits) XOR `PARITY_ODD`. `parity_err` = received parity bit ≠ expected. `parity_err` is forced to 0 when `PARITY_EN`=0.
- `break_det` = `frame_err` AND (data = 0) AND (parity bit = 0 if enabled).
- After a framing error the line may still be low. `armed` blocks a new start until `rxs` has returned high.

## Timing
- Reset values: `rx_data`=0, `rx_busy`=0, `rx_done`=0, all error flags 0, state IDLE, `armed`=0, synchroniser flops 1.
- From an `rx` falling edge to `rx_busy`=1 takes 3 `clk` cycles: 2 synchroniser cycles plus 1 register stage.
- `rx_done` is high for exactly one `clk`, coincident with the first cycle in which the new `rx_data` and flags are valid.
- `rx_data` and all flags hold until the next `rx_done`. Aborted frames do not disturb them.
- A falling edge may be accepted in the cycle immediately after `rx_done`. Back-to-back frames need no idle gap beyond the remaining half stop bit.
- `b_tick` is ignored outside START, DATA, PARITY and STOP. An edge arriving on the same cycle as `b_tick` in IDLE starts the frame with `tcnt`=0; that tick is not counted.
- When `rst_n` is asserted mid-frame, all state clears immediately. After release the block returns to IDLE unarmed, and no `rx_done` is produced for the partial frame.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 → one `rx_done` pulse, `rx_data`=0xA5, all flags 0, `rx_busy` high for about 9.5 bit times.
- `PARITY_EN`=1, even parity: send 0x37 with parity 1 → `parity_err`=0. Send 0x37 with parity 0 → `parity_err`=1 and `rx_data`=0x37.
- `rx` low for 4 ticks and then high → `rx_busy` pulses and falls at tick 9, no `rx_done`, `rx_data` unchanged. A single-tick glitch at mid-bit inside a valid 0x5A frame → still 0x5A.
- Send 0x00 with the stop bit held low and the line kept low for 20 bit times → `frame_err`=1, `break_det`=1, exactly one `rx_done`. No new frame until the line goes high and then low again.
- `DATA_BITS`=7, `STOP_BITS`=2: send 0x41 and 0x7F back-to-back → two `rx_done` pulses, data 0x41 then 0x7F. A low second stop bit → `frame_err`=1.
- Assert `rst_n`=0 during bit 4 of a frame → all outputs 0 immediately. The next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Parametrised UART receiver. Configurable data width, optional
//               parity, one or two stop bits and oversampling ratio. Includes a
//               2-flop input synchroniser, 3-sample majority voting, false-start
//               rejection and parity / framing / break reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_busy,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int TW = $clog2(OVERSAMPLE);

    // Tick positions of the three mid-bit samples and of the bit boundary
    localparam logic [TW-1:0] c_T_V0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_T_V1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] c_T_V2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] c_T_WRAP = TW'(OVERSAMPLE - 1);

    localparam logic [3:0] c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       c_PAR_EN    = (PARITY_EN != 0);
    localparam logic       c_PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic                 r_sync1;
    logic                 r_rxs;
    logic [2:0]           r_state;
    logic                 r_armed;
    logic [TW-1:0]        r_tcnt;
    logic [3:0]           r_bitcnt;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par;
    logic                 r_ferr;

    logic w_tick;
    logic w_samp;
    logic w_vote_ev;
    logic w_wrap;
    logic w_vote;
    logic w_ferr_fin;
    logic w_par_err;
    logic w_brk;

    // Ticks only matter while a frame is being received
    assign w_tick     = b_tick && (r_state != c_ST_IDLE);
    assign w_samp     = w_tick && ((r_tcnt == c_T_V0) || (r_tcnt == c_T_V1) || (r_tcnt == c_T_V2));
    assign w_vote_ev  = w_tick && (r_tcnt == c_T_V2);
    assign w_wrap     = w_tick && (r_tcnt == c_T_WRAP);

    // Majority of the two stored samples and the one arriving on the vote tick
    assign w_vote     = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rxs) | (r_samp[0] & r_rxs);

    // Final frame status, valid on the vote of the last stop bit
    assign w_ferr_fin = r_ferr | ~w_vote;
    assign w_par_err  = c_PAR_EN & (r_par ^ (^r_shreg) ^ c_PAR_ODD);
    assign w_brk      = w_ferr_fin & (r_shreg == '0) & (~c_PAR_EN | ~r_par);

    // Two-flop synchroniser on the asynchronous line, idling high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    // Oversampling tick counter, held at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_tcnt <= '0;
        end else if (w_tick) begin
            r_tcnt <= (r_tcnt == c_T_WRAP) ? '0 : r_tcnt + TW'(1);
        end
    end

    // Capture the first two mid-bit samples for the majority vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp <= 2'b11;
        end else if (w_samp) begin
            r_samp <= {r_samp[0], r_rxs};
        end
    end

    // Frame sequencing, data assembly and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_armed    <= 1'b0;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_ferr     <= 1'b0;
            rx_data    <= '0;
            rx_busy    <= 1'b0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A start edge only counts once the line has been seen high
                    if (!r_armed) begin
                        r_armed <= r_rxs;
                    end else if (!r_rxs) begin
                        r_bitcnt <= '0;
                        r_shreg  <= '0;
                        r_par    <= 1'b0;
                        r_ferr   <= 1'b0;
                        rx_busy  <= 1'b1;
                        r_armed  <= 1'b0;
                        r_state  <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_vote_ev && w_vote) begin
                        rx_busy <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else if (w_wrap) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_vote_ev) begin
                        r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
                    end
                    if (w_wrap) begin
                        if (r_bitcnt == c_LAST_DATA) begin
                            r_bitcnt <= '0;
                            r_state  <= c_PAR_EN ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_vote_ev) begin
                        r_par <= w_vote;
                    end
                    if (w_wrap) begin
                        r_state <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_vote_ev) begin
                        if (r_bitcnt == c_LAST_STOP) begin
                            // Finish at mid-bit so a back-to-back start is not missed
                            rx_data    <= r_shreg;
                            parity_err <= w_par_err;
                            frame_err  <= w_ferr_fin;
                            break_det  <= w_brk;
                            rx_done    <= 1'b1;
                            rx_busy    <= 1'b0;
                            r_armed    <= r_rxs;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_ferr <= w_ferr_fin;
                        end
                    end else if (w_wrap) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
                default: begin
                    rx_busy <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Self-checking bench for uart_rx_cfg. Three instances cover
//               8N1/x16, 8E1/x16 and 7N2/x8. Frames are generated at the bit
//               level and the expected word and flags per frame are derived
//               from the frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    typedef struct {
        int         w;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       b_tick;
    logic [2:0] rx_l;

    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] d2;
    logic [8:0] dout [3];
    logic [2:0] busy_o;
    logic [2:0] done_o;
    logic [2:0] pe_o;
    logic [2:0] fe_o;
    logic [2:0] bd_o;

    int nb    [3] = '{8, 8, 7};
    int os    [3] = '{16, 16, 8};
    int pen   [3] = '{0, 1, 0};
    int nstop [3] = '{1, 1, 2};

    int         checks;
    int         errors;
    int         tick_cnt;
    int         busy_cyc0;
    exp_t       expq [$];
    logic [11:0] hold_st [3];

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .rx(rx_l[0]),
        .rx_data(d0), .rx_busy(busy_o[0]), .rx_done(done_o[0]),
        .parity_err(pe_o[0]), .frame_err(fe_o[0]), .break_det(bd_o[0]));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .rx(rx_l[1]),
        .rx_data(d1), .rx_busy(busy_o[1]), .rx_done(done_o[1]),
        .parity_err(pe_o[1]), .frame_err(fe_o[1]), .break_det(bd_o[1]));

    uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .rx(rx_l[2]),
        .rx_data(d2), .rx_busy(busy_o[2]), .rx_done(done_o[2]),
        .parity_err(pe_o[2]), .frame_err(fe_o[2]), .break_det(bd_o[2]));

    assign dout[0] = {1'b0, d0};
    assign dout[1] = {1'b0, d1};
    assign dout[2] = {2'b00, d2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clk pulse every third cycle, counted for bit timing
    initial begin
        int div;
        div      = 0;
        b_tick   = 1'b0;
        tick_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            div    = (div + 1) % 3;
            b_tick = (div == 0);
            if (b_tick) tick_cnt++;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Parity over the low n bits, seeded with the odd/even selector
    function automatic logic calc_par(input logic [8:0] d, input int n, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < n; i++) p = p ^ d[i];
        return p;
    endfunction

    task automatic wait_ticks(input int n);
        int t0;
        t0 = tick_cnt;
        while (tick_cnt < t0 + n) @(negedge clk);
    endtask

    task automatic drive_bit(input int w, input logic v, input logic glitch);
        rx_l[w] = v;
        if (glitch) begin
            wait_ticks(os[w] / 2);
            rx_l[w] = ~v;
            wait_ticks(1);
            rx_l[w] = v;
            wait_ticks(os[w] / 2 - 1);
        end else begin
            wait_ticks(os[w]);
        end
    endtask

    // Send one frame (even parity bit, optionally flipped) and queue its expectation
    task automatic send_frame(input int w, input logic [8:0] d, input logic par_flip,
                              input logic [1:0] stop_low, input int gl_bit);
        exp_t       e;
        logic       pb;
        logic [1:0] smask;
        pb     = calc_par(d, nb[w], 1'b0) ^ par_flip;
        smask  = (nstop[w] == 2) ? 2'b11 : 2'b01;
        e.w    = w;
        e.data = d;
        e.pe   = (pen[w] != 0) && (pb != calc_par(d, nb[w], 1'b0));
        e.fe   = ((stop_low & smask) != 2'b00);
        e.bd   = e.fe && (d == 9'd0) && ((pen[w] == 0) || (pb == 1'b0));
        expq.push_back(e);
        drive_bit(w, 1'b0, 1'b0);
        for (int i = 0; i < nb[w]; i++) drive_bit(w, d[i], (i == gl_bit));
        if (pen[w] != 0) drive_bit(w, pb, 1'b0);
        for (int s = 0; s < nstop[w]; s++) drive_bit(w, ~stop_low[s], 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
        chk(name, expq.size(), 0);
    endtask

    // Every-cycle comparison of all instances against the frame-level model
    initial begin
        logic [11:0] st;
        exp_t        e;
        for (int w = 0; w < 3; w++) hold_st[w] = '0;
        forever begin
            @(negedge clk);
            for (int w = 0; w < 3; w++) begin
                st = {dout[w], pe_o[w], fe_o[w], bd_o[w]};
                if (!rst_n) begin
                    chk($sformatf("dut%0d_in_reset", w), {st, busy_o[w], done_o[w]}, 0);
                    hold_st[w] = '0;
                end else if (done_o[w]) begin
                    chk($sformatf("dut%0d_busy_at_done", w), busy_o[w], 0);
                    if (expq.size() == 0 || expq[0].w != w) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d_unexpected_done: got rx_done=1 expected 0", w);
                    end else begin
                        e = expq.pop_front();
                        chk($sformatf("dut%0d_frame", w), st, {e.data, e.pe, e.fe, e.bd});
                        hold_st[w] = {e.data, e.pe, e.fe, e.bd};
                    end
                end else begin
                    chk($sformatf("dut%0d_hold", w), st, hold_st[w]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (busy_o[0]) busy_cyc0++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [8:0] d;
        logic       pf;
        logic [1:0] sl;
        logic       seen;
        int         t0;
        int         fall_t;
        checks    = 0;
        errors    = 0;
        busy_cyc0 = 0;
        rst_n     = 1'b0;
        rx_l      = 3'b111;

        // Reset state and model pins
        repeat (4) @(negedge clk);
        chk("reset_state", {dout[0], dout[1], dout[2], busy_o, done_o, pe_o, fe_o, bd_o}, 0);
        chk("model_par_0x37_even", calc_par(9'h037, 8, 1'b0), 1);
        chk("model_par_0x41_7b", calc_par(9'h041, 7, 1'b0), 0);
        chk("model_par_0x37_odd", calc_par(9'h037, 8, 1'b1), 0);
        #2 rst_n = 1'b1;
        wait_ticks(40);

        // 8N1 0xA5 with busy length of about 9.5 bit times (48 clk per bit)
        busy_cyc0 = 0;
        send_frame(0, 9'h0A5, 1'b0, 2'b00, -1);
        drain("a5_drain");
        chk("a5_data_literal", {dout[0], pe_o[0], fe_o[0], bd_o[0]}, {9'h0A5, 3'b000});
        chk("a5_busy_len", (busy_cyc0 >= 440 && busy_cyc0 <= 480), 1);

        // Even parity: correct then wrong parity bit
        send_frame(1, 9'h037, 1'b0, 2'b00, -1);
        drain("p37_ok_drain");
        chk("p37_ok_perr", pe_o[1], 0);
        send_frame(1, 9'h037, 1'b1, 2'b00, -1);
        drain("p37_bad_drain");
        chk("p37_bad_literal", {dout[1], pe_o[1]}, {9'h037, 1'b1});

        // False start: 4 ticks low
        seen   = 1'b0;
        fall_t = -1;
        t0     = tick_cnt;
        rx_l[0] = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tick_cnt >= t0 + 4) rx_l[0] = 1'b1;
            if (busy_o[0]) seen = 1'b1;
            if (seen && !busy_o[0]) begin
                fall_t = tick_cnt - t0;
                break;
            end
        end
        chk("false_start_busy_seen", seen, 1);
        chk("false_start_busy_fall_tick", (fall_t >= 8 && fall_t <= 12), 1);
        wait_ticks(32);
        chk("false_start_data_kept", dout[0], 9'h0A5);

        // Single-tick glitch at mid-bit inside 0x5A (bit 1 is a one)
        send_frame(0, 9'h05A, 1'b0, 2'b00, 1);
        drain("glitch_drain");
        chk("glitch_data_literal", dout[0], 9'h05A);

        // Break: 0x00 with low stop bit, line held low 20 bit times
        send_frame(0, 9'h000, 1'b0, 2'b01, -1);
        drain("break_drain");
        busy_cyc0 = 0;
        wait_ticks(20 * 16);
        chk("break_no_restart", busy_cyc0, 0);
        chk("break_flags_literal", {fe_o[0], bd_o[0]}, 2'b11);
        rx_l[0] = 1'b1;
        wait_ticks(32);
        send_frame(0, 9'h03C, 1'b0, 2'b00, -1);
        drain("after_break_drain");

        // 7N2 back-to-back, then a low second stop bit
        send_frame(2, 9'h041, 1'b0, 2'b00, -1);
        send_frame(2, 9'h07F, 1'b0, 2'b00, -1);
        drain("b2b_drain");
        chk("b2b_last_literal", dout[2], 9'h07F);
        send_frame(2, 9'h055, 1'b0, 2'b10, -1);
        rx_l[2] = 1'b1;
        drain("stop2_drain");
        chk("stop2_fe_literal", {dout[2], fe_o[2], bd_o[2]}, {9'h055, 2'b10});
        wait_ticks(16);

        // Reset during bit 4 of 0xC3, then a clean 0xC3
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, (i < 2), 1'b0);
        rx_l[0] = 1'b0;
        wait_ticks(8);
        chk("midframe_busy", busy_o[0], 1);
        #2 rst_n = 1'b0;
        #1 chk("reset_immediate", {dout[0], busy_o[0], done_o[0], pe_o[0], fe_o[0], bd_o[0]}, 0);
        rx_l[0] = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ticks(32);
        chk("post_reset_idle", busy_o[0], 0);
        send_frame(0, 9'h0C3, 1'b0, 2'b00, -1);
        drain("c3_drain");
        chk("c3_literal", dout[0], 9'h0C3);

        // Randomized frames on each configuration
        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < 12; n++) begin
                d  = 9'($urandom) & 9'((1 << nb[w]) - 1);
                pf = (pen[w] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                sl = 2'b00;
                if ($urandom_range(0, 5) == 0)
                    sl = (nstop[w] == 2) ? 2'($urandom_range(1, 3)) : 2'b01;
                send_frame(w, d, pf, sl, -1);
                rx_l[w] = 1'b1;
                if (sl != 2'b00) wait_ticks(os[w]);
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
            drain($sformatf("rand_dut%0d_drain", w));
            wait_ticks(8);
        end

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
